fpu_cvt_arbiter: RTL and testbench

//  Shares one multi-cycle float->unsigned-int converter (en/complete handshake) between N_REQ requesters.

---
 rtl/fpu_cvt_pkg.sv | 19 +
 rtl/fpu_cvt_arbiter_rr_pick.sv | 42 ++++
 rtl/fpu_cvt_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fpu_cvt_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_cvt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpu_cvt_pkg : shared types and constants for the converter arbiter   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package fpu_cvt_pkg;

  localparam int CVT_W     = 32;
  localparam int TMO_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fpu_cvt_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : round-robin picker, first request after last_grant wins    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rr_pick
  import fpu_cvt_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  int              pos;
  logic [ID_W-1:0] cand;

  // Scan starts one past the previous winner and wraps, so the previous
  // winner is considered last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos  = (int'(last) + k) % N_REQ;
      cand = ID_W'(pos);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_cvt_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpu_cvt_arbiter : shares one multi-cycle float->uint converter among |
// | N_REQ requesters. Optional abort timer: FPU_CVT_TIMEOUT_EN.          |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module fpu_cvt_arbiter
  import fpu_cvt_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [CVT_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [CVT_W-1:0]       cvt_a,
  output logic                   cvt_en,
  output logic                   cvt_rst,
  input  logic                   cvt_complete,
  input  logic [CVT_W-1:0]       cvt_z,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [CVT_W-1:0]       rsp_data,
  input  logic                   rsp_ready,
  output logic                   busy
`ifdef FPU_CVT_TIMEOUT_EN
  ,
  output logic                   rsp_err
`endif
);

  if (ID_W != $clog2(N_REQ) || N_REQ < 2 || N_REQ > 8) begin : g_bad_cfg
    $error("fpu_cvt_arbiter: N_REQ must be 2..8 and ID_W must equal clog2(N_REQ)");
  end
  if (TIMEOUT < 1 || TIMEOUT > (1 << TMO_CNT_W) - 1) begin : g_bad_timeout
    $error("fpu_cvt_arbiter: TIMEOUT out of range for the abort counter");
  end

  state_t           state_q, state_d;
  logic [CVT_W-1:0] op_q, op_d;
  logic [CVT_W-1:0] res_q, res_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic             abort_w;

  logic [N_REQ-1:0] pick_grant;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic [CVT_W-1:0] req_word [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_word[i] = req_data[CVT_W*i +: CVT_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req   (req_valid),
    .last  (last_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef FPU_CVT_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);
  logic [TMO_CNT_W-1:0] tmo_q, tmo_d;
  logic                 err_q, err_d;
  assign abort_w = err_q;
  assign rsp_err = err_q && (state_q == ST_RESP);
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    res_d     = res_q;
    id_d      = id_q;
    last_d    = last_q;
    req_ready = '0;
    cvt_en    = 1'b0;
    cvt_rst   = 1'b0;
    rsp_valid = 1'b0;
`ifdef FPU_CVT_TIMEOUT_EN
    tmo_d     = tmo_q;
    err_d     = err_q;
`endif
    case (state_q)
      ST_FLUSH: begin
        cvt_en  = 1'b1;
        cvt_rst = 1'b1;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (pick_any) begin
          req_ready = pick_grant;
          op_d      = req_word[pick_idx];
          id_d      = pick_idx;
          state_d   = ST_WAIT;
`ifdef FPU_CVT_TIMEOUT_EN
          tmo_d     = '0;
          err_d     = 1'b0;
`endif
        end
      end
      ST_WAIT: begin
        cvt_en = 1'b1;
        if (cvt_complete) begin
          res_d   = cvt_z;
          state_d = ST_RESP;
        end
`ifdef FPU_CVT_TIMEOUT_EN
        // The converter is left mid-operation; FLUSH after the handshake resets it.
        else if (tmo_q == TMO_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = abort_w ? ST_FLUSH : ST_IDLE;
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FLUSH;
      op_q    <= '0;
      res_q   <= '0;
      id_q    <= '0;
      last_q  <= ID_W'(N_REQ - 1);
`ifdef FPU_CVT_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      id_q    <= id_d;
      last_q  <= last_d;
`ifdef FPU_CVT_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign cvt_a    = op_q;
  assign rsp_id   = id_q;
  assign rsp_data = res_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpu_cvt_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fpu_cvt_arbiter : randomized bench with converter and arbiter     |
// | reference models. Revision : 1.0                                     |
// +----------------------------------------------------------------------+
module tb_fpu_cvt_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [31:0]     cvt_a;
  logic            cvt_en, cvt_rst;
  logic            cvt_complete;
  logic            m_cpl = 1'b0;
  logic            spur = 1'b0;
  logic [31:0]     cvt_z = '0;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [31:0]     rsp_data;
  logic            rsp_ready = 1'b0;
  logic            busy;
`ifdef FPU_CVT_TIMEOUT_EN
  logic            rsp_err;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign cvt_complete = m_cpl | spur;

  fpu_cvt_arbiter #(.N_REQ(N), .ID_W(IDW), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .cvt_a        (cvt_a),
    .cvt_en       (cvt_en),
    .cvt_rst      (cvt_rst),
    .cvt_complete (cvt_complete),
    .cvt_z        (cvt_z),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .busy         (busy)
`ifdef FPU_CVT_TIMEOUT_EN
    ,
    .rsp_err      (rsp_err)
`endif
  );

  // Truncating float -> unsigned conversion, saturating above 2^32-1.
  function automatic logic [31:0] f2u(input logic [31:0] a);
    int          e;
    logic [63:0] m;
    if (a[31]) return 32'h0;
    if (a[30:23] == 8'hFF) return 32'hFFFF_FFFF;
    e = int'(a[30:23]) - 127;
    if (e < 0) return 32'h0;
    if (e >= 32) return 32'hFFFF_FFFF;
    m = {40'd0, 1'b1, a[22:0]};
    if (e >= 23) m = m << (e - 23);
    else         m = m >> (23 - e);
    return m[31:0];
  endfunction

  // Converter model: latency m_lat+2 cycles of enable; m_stall never finishes.
  int m_lat = 0;
  bit m_stall = 1'b0;
  int m_cnt = 0;
  always @(posedge clk) begin
    if (!cvt_en || cvt_rst) begin
      m_cnt <= 0;
      m_cpl <= 1'b0;
      cvt_z <= $urandom;
    end else if (m_cpl) begin
      m_cpl <= 1'b0;
      cvt_z <= $urandom;
    end else if (!m_stall && m_cnt >= m_lat) begin
      m_cpl <= 1'b1;
      cvt_z <= f2u(cvt_a);
    end else begin
      m_cnt <= m_cnt + 1;
      cvt_z <= $urandom;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Requester-side reference state.
  bit          pend_v [N];
  logic [31:0] pend_d [N];
  int          last_g = N - 1;
  logic [N-1:0] gnt_log [$];

  function automatic int model_pick();
    for (int k = 1; k <= N; k++) begin
      if (pend_v[(last_g + k) % N]) return (last_g + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] f;
    f = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      f[31]    = ($urandom_range(0, 3) == 0);
      f[30:23] = 8'($urandom_range(120, 162));
    end
    return f;
  endfunction

  task automatic apply_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pend_v[i];
      req_data[32*i +: 32]  = pend_d[i];
    end
  endtask

  task automatic churn_reqs();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        pend_v[i] = !pend_v[i];
        if (pend_v[i]) pend_d[i] = rand_float();
      end
    end
  endtask

  // One arbitration slot starting in IDLE at posedge+1; ends in IDLE at posedge+1.
  task automatic serve(input int hold, input bit churn, input bit keep);
    int           g, cyc, exp_cyc;
    logic [31:0]  op, exp_z;
    logic [N-1:0] oh;
    apply_reqs();
    @(negedge clk);
    g = model_pick();
    if (g < 0) begin
      check("idle_no_ready", req_ready, 0);
      @(posedge clk); #1;
      return;
    end
    oh = '0;
    oh[g] = 1'b1;
    check("grant", req_ready, oh);
    check("busy_idle", busy, 0);
    gnt_log.push_back(req_ready);
    op      = pend_d[g];
    exp_z   = m_stall ? 32'h0 : f2u(op);
    exp_cyc = m_stall ? TMO + 1 : m_lat + 3;
    if (!keep) pend_v[g] = 1'b0;
    @(posedge clk); #1;
    rsp_ready = (hold == 0);
    apply_reqs();
    @(negedge clk);
    cyc = 1;
    check("cvt_a", cvt_a, op);
    check("wait_en_rst", {cvt_en, cvt_rst}, 2'b10);
    check("busy_wait", busy, 1);
    while (!rsp_valid && cyc < 300) begin
      @(posedge clk); #1;
      if (churn) churn_reqs();
      apply_reqs();
      @(negedge clk);
      cyc++;
    end
    check("rsp_valid_seen", rsp_valid, 1);
    if (!rsp_valid) return;
    check("latency", cyc, exp_cyc);
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", rsp_valid, 1);
      check("hold_id", rsp_id, g);
      check("hold_data", rsp_data, exp_z);
      check("hold_req_ready", req_ready, 0);
      check("hold_cvt_en", cvt_en, 0);
      @(posedge clk); #1;
      spur = $urandom_range(0, 1);
      if (churn) churn_reqs();
      apply_reqs();
      if (h == hold - 1) rsp_ready = 1'b1;
      @(negedge clk);
    end
    check("rsp_valid", rsp_valid, 1);
    check("rsp_id", rsp_id, g);
    check("rsp_data", rsp_data, exp_z);
    check("resp_req_ready", req_ready, 0);
    check("resp_cvt_en", cvt_en, 0);
`ifdef FPU_CVT_TIMEOUT_EN
    check("rsp_err", rsp_err, m_stall);
`endif
    last_g = g;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    spur = 1'b0;
    if (m_stall) begin
      @(negedge clk);
      check("abort_flush", {cvt_en, cvt_rst}, 2'b11);
      check("abort_no_rsp", rsp_valid, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0;
      pend_d[i] = 32'h0;
    end
  endtask

  logic [N-1:0] exp_order [5];

  initial begin
    clear_reqs();
    req_valid = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flush", {cvt_en, cvt_rst}, 2'b11);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    apply_reqs();
    @(negedge clk);
    check("flush_after_rst", {cvt_en, cvt_rst}, 2'b11);
    @(posedge clk); #1;

    // All requesters held valid: rotation starting at requester 0.
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b1;
      pend_d[i] = 32'h3F80_0000;
    end
    for (int t = 0; t < 5; t++) serve(0, 0, 1);
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int t = 0; t < 5; t++) check("rr_order", gnt_log[t], exp_order[t]);
    clear_reqs();

    pend_v[0] = 1'b1; pend_d[0] = 32'h4040_0000;
    serve(0, 0, 0);
    m_lat = 2;
    pend_v[1] = 1'b1; pend_d[1] = 32'hBF80_0000;
    serve(0, 0, 0);
    pend_v[1] = 1'b1; pend_d[1] = 32'h4F80_0000;
    serve(0, 0, 0);
    pend_v[2] = 1'b1; pend_d[2] = 32'h3F80_0000;
    serve(5, 0, 0);

    // Reset in the middle of a conversion.
    m_stall = 1'b1;
    pend_v[0] = 1'b1; pend_d[0] = 32'h4120_0000;
    apply_reqs();
    @(negedge clk);
    check("rstw_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    pend_v[0] = 1'b0;
    pend_v[2] = 1'b1; pend_d[2] = 32'h4000_0000;
    apply_reqs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_stall = 1'b0;
    @(negedge clk);
    check("rstw_flush", {cvt_en, cvt_rst}, 2'b11);
    check("rstw_rsp_valid", rsp_valid, 0);
    check("rstw_req_ready", req_ready, 0);
    @(posedge clk); #1;
    last_g = N - 1;
    pend_v[0] = 1'b1; pend_d[0] = 32'h4120_0000;
    serve(0, 0, 0);
    serve(1, 0, 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      m_lat = $urandom_range(0, 5);
      churn_reqs();
      serve($urandom_range(0, 3), 1, 0);
    end

`ifdef FPU_CVT_TIMEOUT_EN
    clear_reqs();
    m_stall = 1'b1;
    pend_v[3] = 1'b1; pend_d[3] = 32'h4040_0000;
    serve(1, 0, 0);
    m_stall = 1'b0;
    m_lat = 1;
    pend_v[3] = 1'b1; pend_d[3] = 32'h4040_0000;
    serve(0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
`default_nettype wire
